control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/minisrc_pkg.sv | 43 ++++
 rtl/control_unit_if.sv | 21 ++
 rtl/control_decode.sv | 45 ++++
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/minisrc_pkg.sv
// rtl/minisrc_pkg.sv - shared opcode, ALU, bus-select, control-bit and state definitions
package minisrc_pkg;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15, OP_MUL  = 5'd16, OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18, OP_BRX  = 5'd19, OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // Code 0 is reserved for "no ALU operation" so ALU_op reads 0 whenever e_Z is low
    localparam logic [3:0] ALU_NONE = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3,  ALU_OR  = 4'd4,  ALU_ROR = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6,  ALU_SHR = 4'd7,  ALU_SHRA = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9,  ALU_DIV = 4'd10, ALU_MUL = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12, ALU_NOT = 4'd13;

    localparam logic [4:0] BUS_HI  = 5'd16, BUS_LO  = 5'd17, BUS_ZHI    = 5'd18;
    localparam logic [4:0] BUS_ZLO = 5'd19, BUS_PC  = 5'd20, BUS_MDR    = 5'd21;
    localparam logic [4:0] BUS_INPORT = 5'd22, BUS_IMM = 5'd23;

    localparam int CE_MDR_READ = 15, CE_RAM_WRITE = 14, CE_RAM_READ = 13, CE_INCPC = 12;
    localparam int CE_CON_FF   = 11, CE_RA  = 10, CE_INPORT = 9, CE_OUTPORT = 8;
    localparam int CE_MAR      = 7,  CE_MDR = 6,  CE_LO = 5, CE_HI = 4;
    localparam int CE_Z        = 3,  CE_Y   = 2,  CE_IR = 1, CE_PC = 0;

    localparam int RC_IMM_SEL = 6, RC_BAOUT = 5, RC_EROUT = 4, RC_ERIN = 3;
    localparam int RC_GRC     = 2, RC_GRB   = 1, RC_GRA   = 0;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_PAUSE
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_LD, CL_LDI, CL_ST, CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY,
        CL_BRX, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } iclass_e;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction/condition inputs and control outputs of the sequencer
interface control_unit_if;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic [15:0] ctl_en;
    logic [6:0]  reg_ctl;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic        run;

    modport master (
        input  ir, con, stop,
        output ctl_en, reg_ctl, ALU_op, BusDataSelect, run
    );

    modport slave (
        output ir, con, stop,
        input  ctl_en, reg_ctl, ALU_op, BusDataSelect, run
    );
endinterface

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode to instruction class and ALU operation
module control_decode
    import minisrc_pkg::*;
(
    input  logic [4:0] op_i,
    output iclass_e    cls_o,
    output logic [3:0] alu_o
);

    always_comb begin
        cls_o = CL_NOP;
        alu_o = ALU_NONE;
        case (op_i)
            OP_LD:   cls_o = CL_LD;
            OP_LDI:  cls_o = CL_LDI;
            OP_ST:   cls_o = CL_ST;
            OP_ADD:  begin cls_o = CL_ALU;    alu_o = ALU_ADD;  end
            OP_SUB:  begin cls_o = CL_ALU;    alu_o = ALU_SUB;  end
            OP_AND:  begin cls_o = CL_ALU;    alu_o = ALU_AND;  end
            OP_OR:   begin cls_o = CL_ALU;    alu_o = ALU_OR;   end
            OP_ROR:  begin cls_o = CL_ALU;    alu_o = ALU_ROR;  end
            OP_ROL:  begin cls_o = CL_ALU;    alu_o = ALU_ROL;  end
            OP_SHR:  begin cls_o = CL_ALU;    alu_o = ALU_SHR;  end
            OP_SHRA: begin cls_o = CL_ALU;    alu_o = ALU_SHRA; end
            OP_SHL:  begin cls_o = CL_ALU;    alu_o = ALU_SHL;  end
            OP_ADDI: begin cls_o = CL_IMM;    alu_o = ALU_ADD;  end
            OP_ANDI: begin cls_o = CL_IMM;    alu_o = ALU_AND;  end
            OP_ORI:  begin cls_o = CL_IMM;    alu_o = ALU_OR;   end
            OP_DIV:  begin cls_o = CL_MULDIV; alu_o = ALU_DIV;  end
            OP_MUL:  begin cls_o = CL_MULDIV; alu_o = ALU_MUL;  end
            OP_NEG:  begin cls_o = CL_UNARY;  alu_o = ALU_NEG;  end
            OP_NOT:  begin cls_o = CL_UNARY;  alu_o = ALU_NOT;  end
            OP_BRX:  cls_o = CL_BRX;
            OP_JR:   cls_o = CL_JR;
            OP_JAL:  cls_o = CL_JAL;
            OP_IN:   cls_o = CL_IN;
            OP_OUT:  cls_o = CL_OUT;
            OP_MFHI: cls_o = CL_MFHI;
            OP_MFLO: cls_o = CL_MFLO;
            OP_HALT: cls_o = CL_HALT;
            default: cls_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - T0-T7 fetch/execute sequencer with halt and pause states
module control_unit
    import minisrc_pkg::*;
(
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);

    state_e     state_q, state_d;
    iclass_e    cls;
    logic [3:0] dec_alu;
    logic [15:0] ctl;
    logic [6:0]  rgc;
    logic [3:0]  alu;
    logic [4:0]  bus;
    logic        run;
    logic        done;
    logic        unused_ir;

    assign unused_ir = ^cu.ir[14:0];

    control_decode u_decode (
        .op_i  (cu.ir[31:27]),
        .cls_o (cls),
        .alu_o (dec_alu)
    );

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_T0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        rgc     = '0;
        alu     = ALU_NONE;
        bus     = '0;
        run     = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_T0: begin bus = BUS_PC; ctl[CE_MAR] = 1'b1; ctl[CE_INCPC] = 1'b1; state_d = S_T1; end
            S_T1: begin
                ctl[CE_RAM_READ] = 1'b1; ctl[CE_MDR_READ] = 1'b1; ctl[CE_MDR] = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin bus = BUS_MDR; ctl[CE_IR] = 1'b1; state_d = S_T3; end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    CL_LD, CL_LDI, CL_ST: begin
                        rgc[RC_GRB] = 1'b1; rgc[RC_BAOUT] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_Y] = 1'b1;
                    end
                    CL_ALU, CL_IMM: begin rgc[RC_GRB] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_Y] = 1'b1; end
                    CL_MULDIV: begin rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_Y] = 1'b1; end
                    CL_UNARY: begin
                        rgc[RC_GRB] = 1'b1; rgc[RC_EROUT] = 1'b1; alu = dec_alu; ctl[CE_Z] = 1'b1;
                    end
                    CL_BRX: begin rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_RA] = 1'b1; end
                    CL_JR:  begin rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_PC] = 1'b1; done = 1'b1; end
                    CL_JAL: begin bus = BUS_PC; rgc[RC_GRB] = 1'b1; rgc[RC_ERIN] = 1'b1; end
                    CL_IN:  ctl[CE_INPORT] = 1'b1;
                    CL_OUT: begin rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_OUTPORT] = 1'b1; done = 1'b1; end
                    CL_MFHI: begin bus = BUS_HI; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1; done = 1'b1; end
                    CL_MFLO: begin bus = BUS_LO; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1; done = 1'b1; end
                    CL_HALT: state_d = S_HALT;
                    default: done = 1'b1;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    CL_LD, CL_LDI, CL_ST: begin
                        rgc[RC_IMM_SEL] = 1'b1; bus = BUS_IMM; alu = ALU_ADD; ctl[CE_Z] = 1'b1;
                    end
                    CL_ALU: begin rgc[RC_GRC] = 1'b1; rgc[RC_EROUT] = 1'b1; alu = dec_alu; ctl[CE_Z] = 1'b1; end
                    CL_IMM: begin rgc[RC_IMM_SEL] = 1'b1; bus = BUS_IMM; alu = dec_alu; ctl[CE_Z] = 1'b1; end
                    CL_MULDIV: begin rgc[RC_GRB] = 1'b1; rgc[RC_EROUT] = 1'b1; alu = dec_alu; ctl[CE_Z] = 1'b1; end
                    CL_UNARY: begin bus = BUS_ZLO; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1; done = 1'b1; end
                    CL_BRX: ctl[CE_CON_FF] = 1'b1;
                    CL_JAL: begin rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_PC] = 1'b1; done = 1'b1; end
                    CL_IN:  begin bus = BUS_INPORT; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1; done = 1'b1; end
                    default: done = 1'b1;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    CL_LDI, CL_ALU, CL_IMM: begin
                        bus = BUS_ZLO; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1; done = 1'b1;
                    end
                    CL_LD, CL_ST: begin bus = BUS_ZLO; ctl[CE_MAR] = 1'b1; end
                    CL_MULDIV:    begin bus = BUS_ZLO; ctl[CE_LO] = 1'b1; end
                    CL_BRX:       begin bus = BUS_PC;  ctl[CE_Y] = 1'b1; end
                    default: done = 1'b1;
                endcase
            end
            S_T6: begin
                state_d = S_T7;
                case (cls)
                    CL_LD: begin
                        ctl[CE_RAM_READ] = 1'b1; ctl[CE_MDR_READ] = 1'b1; ctl[CE_MDR] = 1'b1;
                    end
                    CL_ST: begin
                        rgc[RC_GRA] = 1'b1; rgc[RC_EROUT] = 1'b1; ctl[CE_RAM_WRITE] = 1'b1; done = 1'b1;
                    end
                    CL_MULDIV: begin bus = BUS_ZHI; ctl[CE_HI] = 1'b1; done = 1'b1; end
                    CL_BRX: begin rgc[RC_IMM_SEL] = 1'b1; alu = ALU_ADD; ctl[CE_Z] = 1'b1; end
                    default: done = 1'b1;
                endcase
            end
            S_T7: begin
                done = 1'b1;
                if (cls == CL_LD) begin
                    bus = BUS_MDR; rgc[RC_GRA] = 1'b1; rgc[RC_ERIN] = 1'b1;
                end else if (cls == CL_BRX && cu.con) begin
                    bus = BUS_ZLO; ctl[CE_PC] = 1'b1;
                end
            end
            S_HALT:  run = 1'b0;
            S_PAUSE: begin
                run = 1'b0;
                if (!cu.stop) state_d = S_T0;
            end
            default: state_d = S_T0;
        endcase

        // A pause request is honoured only at the instruction boundary
        if (done) state_d = cu.stop ? S_PAUSE : S_T0;

        // Register reads always drive the bus from the selected IR field
        if (rgc[RC_EROUT]) begin
            if (rgc[RC_GRA])      bus = {1'b0, cu.ir[26:23]};
            else if (rgc[RC_GRB]) bus = {1'b0, cu.ir[22:19]};
            else                  bus = {1'b0, cu.ir[18:15]};
        end
    end

    assign cu.ctl_en        = ctl;
    assign cu.reg_ctl       = rgc;
    assign cu.ALU_op        = alu;
    assign cu.BusDataSelect = bus;
    assign cu.run           = run;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized and directed checks of control_unit against a step-table model
module tb_control_unit;
    import minisrc_pkg::*;

    localparam int B_MDR_READ = 15, B_RAM_WRITE = 14, B_RAM_READ = 13, B_INCPC = 12;
    localparam int B_CON = 11, B_RA = 10, B_INP = 9, B_OUTP = 8, B_MAR = 7, B_MDR = 6;
    localparam int B_LO = 5, B_HI = 4, B_Z = 3, B_Y = 2, B_IR = 1, B_PC = 0;
    localparam int R_IMM = 6, R_BA = 5, R_ROUT = 4, R_RIN = 3, R_GRC = 2, R_GRB = 1, R_GRA = 0;
    localparam int M_RUN = 0, M_HALT = 1, M_PAUSE = 2;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;
    int   m_mode = M_RUN;
    int   m_k = 0;

    control_unit_if cu_if ();
    control_unit dut (.clock(clock), .clear(clear), .cu(cu_if));

    always #5 clock = ~clock;

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return ALU_ADD;
            5'd4:        return ALU_SUB;
            5'd5, 5'd13: return ALU_AND;
            5'd6, 5'd14: return ALU_OR;
            5'd7:  return ALU_ROR;
            5'd8:  return ALU_ROL;
            5'd9:  return ALU_SHR;
            5'd10: return ALU_SHRA;
            5'd11: return ALU_SHL;
            5'd15: return ALU_DIV;
            5'd16: return ALU_MUL;
            5'd17: return ALU_NEG;
            5'd18: return ALU_NOT;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic int last_k(input logic [4:0] op);
        if (op == 5'd0 || op == 5'd19) return 7;
        if (op == 5'd2 || op == 5'd15 || op == 5'd16) return 6;
        if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 5;
        if (op == 5'd17 || op == 5'd18 || op == 5'd21 || op == 5'd22) return 4;
        return 3;
    endfunction

    // Expected {run, ctl_en, reg_ctl, ALU_op, BusDataSelect} for a step of an instruction
    function automatic logic [32:0] model_out(input int mode, input int k, input logic [31:0] i, input logic c);
        logic [15:0] ce; logic [6:0] rc; logic [3:0] a; logic [4:0] b; logic [4:0] op;
        logic [4:0] fa, fb, fc;
        ce = '0; rc = '0; a = '0; b = '0; op = i[31:27];
        fa = {1'b0, i[26:23]}; fb = {1'b0, i[22:19]}; fc = {1'b0, i[18:15]};
        if (mode != M_RUN) return '0;
        if (k == 0) begin b = 5'd20; ce[B_MAR] = 1; ce[B_INCPC] = 1; end
        else if (k == 1) begin ce[B_RAM_READ] = 1; ce[B_MDR_READ] = 1; ce[B_MDR] = 1; end
        else if (k == 2) begin b = 5'd21; ce[B_IR] = 1; end
        else if (op <= 5'd2) begin
            if (k == 3) begin rc[R_GRB] = 1; rc[R_BA] = 1; rc[R_ROUT] = 1; b = fb; ce[B_Y] = 1; end
            if (k == 4) begin rc[R_IMM] = 1; b = 5'd23; a = ALU_ADD; ce[B_Z] = 1; end
            if (k == 5 && op == 5'd1) begin b = 5'd19; rc[R_GRA] = 1; rc[R_RIN] = 1; end
            if (k == 5 && op != 5'd1) begin b = 5'd19; ce[B_MAR] = 1; end
            if (k == 6 && op == 5'd0) begin ce[B_RAM_READ] = 1; ce[B_MDR_READ] = 1; ce[B_MDR] = 1; end
            if (k == 6 && op == 5'd2) begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_RAM_WRITE] = 1; end
            if (k == 7 && op == 5'd0) begin b = 5'd21; rc[R_GRA] = 1; rc[R_RIN] = 1; end
        end else if (op <= 5'd14) begin
            if (k == 3) begin rc[R_GRB] = 1; rc[R_ROUT] = 1; b = fb; ce[B_Y] = 1; end
            if (k == 4) begin
                a = alu_of(op); ce[B_Z] = 1;
                if (op <= 5'd11) begin rc[R_GRC] = 1; rc[R_ROUT] = 1; b = fc; end
                else begin rc[R_IMM] = 1; b = 5'd23; end
            end
            if (k == 5) begin b = 5'd19; rc[R_GRA] = 1; rc[R_RIN] = 1; end
        end else case (op)
            5'd15, 5'd16: begin
                if (k == 3) begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_Y] = 1; end
                if (k == 4) begin rc[R_GRB] = 1; rc[R_ROUT] = 1; b = fb; a = alu_of(op); ce[B_Z] = 1; end
                if (k == 5) begin b = 5'd19; ce[B_LO] = 1; end
                if (k == 6) begin b = 5'd18; ce[B_HI] = 1; end
            end
            5'd17, 5'd18: begin
                if (k == 3) begin rc[R_GRB] = 1; rc[R_ROUT] = 1; b = fb; a = alu_of(op); ce[B_Z] = 1; end
                if (k == 4) begin b = 5'd19; rc[R_GRA] = 1; rc[R_RIN] = 1; end
            end
            5'd19: begin
                if (k == 3) begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_RA] = 1; end
                if (k == 4) ce[B_CON] = 1;
                if (k == 5) begin b = 5'd20; ce[B_Y] = 1; end
                if (k == 6) begin rc[R_IMM] = 1; a = ALU_ADD; ce[B_Z] = 1; end
                if (k == 7 && c) begin b = 5'd19; ce[B_PC] = 1; end
            end
            5'd20: begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_PC] = 1; end
            5'd21: begin
                if (k == 3) begin b = 5'd20; rc[R_GRB] = 1; rc[R_RIN] = 1; end
                if (k == 4) begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_PC] = 1; end
            end
            5'd22: begin
                if (k == 3) ce[B_INP] = 1;
                if (k == 4) begin b = 5'd22; rc[R_GRA] = 1; rc[R_RIN] = 1; end
            end
            5'd23: begin rc[R_GRA] = 1; rc[R_ROUT] = 1; b = fa; ce[B_OUTP] = 1; end
            5'd24: begin b = 5'd16; rc[R_GRA] = 1; rc[R_RIN] = 1; end
            5'd25: begin b = 5'd17; rc[R_GRA] = 1; rc[R_RIN] = 1; end
            default: ;
        endcase
        return {1'b1, ce, rc, a, b};
    endfunction

    always @(posedge clock) begin
        if (clear) begin
            m_mode <= M_RUN; m_k <= 0;
        end else if (m_mode == M_PAUSE) begin
            if (!cu_if.stop) begin m_mode <= M_RUN; m_k <= 0; end
        end else if (m_mode == M_RUN) begin
            if (m_k == 3 && cu_if.ir[31:27] == 5'd27) m_mode <= M_HALT;
            else if (m_k >= 3 && m_k == last_k(cu_if.ir[31:27])) begin
                if (cu_if.stop) m_mode <= M_PAUSE;
                m_k <= 0;
            end else m_k <= m_k + 1;
        end
    end

    always @(negedge clock) begin
        logic [32:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = model_out(m_mode, m_k, cu_if.ir, cu_if.con);
            act_v = {cu_if.run, cu_if.ctl_en, cu_if.reg_ctl, cu_if.ALU_op, cu_if.BusDataSelect};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t mode=%0d step=%0d ir=%h got=%h expected=%h",
                         $time, m_mode, m_k, cu_if.ir, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    initial begin
        cu_if.stop = 1'b0;
        cu_if.con  = 1'b0;
        cu_if.ir   = {5'd3, 4'd3, 4'd1, 4'd2, 15'd0};
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        chk_en = 1'b1;

        nxt(); chk("t0_bus", cu_if.BusDataSelect, 20); chk("t0_ctl", cu_if.ctl_en, 16'h1080);
        chk("t0_run", cu_if.run, 1);
        nxt(); chk("t1_ctl", cu_if.ctl_en, 16'hA040);
        nxt(); chk("t2_bus", cu_if.BusDataSelect, 21); chk("t2_ctl", cu_if.ctl_en, 16'h0002);
        nxt(); chk("add_t3_bus", cu_if.BusDataSelect, 1); chk("add_t3_reg", cu_if.reg_ctl, 7'h12);
        chk("add_t3_ctl", cu_if.ctl_en, 16'h0004);
        nxt(); chk("add_t4_bus", cu_if.BusDataSelect, 2); chk("add_t4_ctl", cu_if.ctl_en, 16'h0008);
        chk("add_t4_alu", cu_if.ALU_op, ALU_ADD);
        nxt(); chk("add_t5_bus", cu_if.BusDataSelect, 19); chk("add_t5_reg", cu_if.reg_ctl, 7'h09);
        nxt(); chk("add_next_t0", cu_if.BusDataSelect, 20);

        cu_if.ir = {5'd0, 4'd1, 4'd0, 4'd0, 15'h10};
        nxt(); nxt(); nxt();
        chk("ld_t3_reg", cu_if.reg_ctl, 7'h32); chk("ld_t3_bus", cu_if.BusDataSelect, 0);
        nxt(); nxt(); chk("ld_t5_ctl", cu_if.ctl_en, 16'h0080);
        cu_if.stop = 1'b1;
        nxt(); chk("ld_t6_ctl", cu_if.ctl_en, 16'hA040);
        nxt(); chk("ld_t7_bus", cu_if.BusDataSelect, 21); chk("ld_t7_reg", cu_if.reg_ctl, 7'h09);
        nxt(); chk("pause_run", cu_if.run, 0); chk("pause_ctl", cu_if.ctl_en, 0);
        nxt(); chk("pause_hold", cu_if.run, 0);
        cu_if.stop = 1'b0;
        nxt(); chk("resume_run", cu_if.run, 1); chk("resume_bus", cu_if.BusDataSelect, 20);

        cu_if.ir = {5'd2, 4'd1, 4'd0, 4'd0, 15'h10};
        for (int k = 1; k <= 6; k++) begin
            nxt(); chk($sformatf("st_ramwr_t%0d", k), cu_if.ctl_en[B_RAM_WRITE], (k == 6) ? 1 : 0);
        end
        nxt();

        cu_if.ir = {5'd19, 4'd2, 4'd0, 4'd0, 15'h8};
        for (int k = 1; k <= 7; k++) nxt();
        chk("brx_con0_ctl", cu_if.ctl_en, 16'h0000);
        cu_if.con = 1'b1; #1;
        chk("brx_con1_ctl", cu_if.ctl_en, 16'h0001); chk("brx_con1_bus", cu_if.BusDataSelect, 19);
        nxt();

        cu_if.ir = {5'd27, 27'd0};
        nxt(); nxt(); nxt(); chk("halt_t3_run", cu_if.run, 1);
        for (int k = 0; k < 20; k++) begin nxt(); chk("halt_run", cu_if.run, 0); end
        clear = 1'b1; @(posedge clock); #1 clear = 1'b0;
        nxt(); chk("halt_clr_run", cu_if.run, 1);

        cu_if.ir = {5'd16, 4'd4, 4'd5, 4'd0, 15'd0};
        for (int k = 1; k <= 5; k++) nxt();
        clear = 1'b1; cu_if.stop = 1'b1;
        @(posedge clock); #1 clear = 1'b0; cu_if.stop = 1'b0;
        nxt(); chk("mul_clr_run", cu_if.run, 1); chk("mul_clr_ctl", cu_if.ctl_en, 16'h1080);

        for (int n = 0; n < 4000; n++) begin
            @(posedge clock); #1;
            clear = ($urandom_range(0, 99) == 0) || (m_mode == M_HALT && $urandom_range(0, 7) == 0);
            cu_if.stop = ($urandom_range(0, 5) == 0);
            cu_if.con  = 1'($urandom_range(0, 1));
            if (m_mode == M_RUN && m_k == 0) cu_if.ir = $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
